// File: rtl/xgriscv_pipe_pkg.sv
// xgriscv pipeline shared types.
// Scoreboard entry layout and forward-select encodings.
package xgriscv_pipe_pkg;

    localparam int RFIDX_WIDTH = 5;

    // Forward select value meaning "use the value read in ID".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                   valid;
        logic [RFIDX_WIDTH-1:0] rd;
        logic                   regwrite;
        logic                   load;
    } sbEntry_t;

    // An entry only matters to a consumer when it is live and writes rd.
    function automatic logic entryWrites(sbEntry_t e);
        return e.valid & e.regwrite;
    endfunction

endpackage

// File: rtl/xgriscv_scoreboard_if.sv
// xgriscv scoreboard interface.
// Decode-side requests in, pipeline hold/flush/forward controls out.
interface xgriscv_scoreboard_if #(
    parameter int RFIDX_WIDTH = 5,
    parameter int NSTAGES     = 3,
    parameter int FW          = 3
);

    logic                   id_valid;
    logic [RFIDX_WIDTH-1:0] id_rs1;
    logic [RFIDX_WIDTH-1:0] id_rs2;
    logic                   id_rs1_used;
    logic                   id_rs2_used;
    logic [RFIDX_WIDTH-1:0] id_rd;
    logic                   id_regwrite;
    logic                   id_load;
    logic                   flush;
    logic                   mem_stall;

    logic                   pc_hold;
    logic                   ifid_hold;
    logic                   ifid_flush;
    logic                   idex_bubble;
    logic                   pipe_freeze;
    logic [FW-1:0]          fwd_a_e;
    logic [FW-1:0]          fwd_b_e;
    logic [NSTAGES-1:0]     busy_mask;

    // Pipeline side: presents the ID instruction, consumes controls.
    modport master (
        output id_valid,
        output id_rs1,
        output id_rs2,
        output id_rs1_used,
        output id_rs2_used,
        output id_rd,
        output id_regwrite,
        output id_load,
        output flush,
        output mem_stall,
        input  pc_hold,
        input  ifid_hold,
        input  ifid_flush,
        input  idex_bubble,
        input  pipe_freeze,
        input  fwd_a_e,
        input  fwd_b_e,
        input  busy_mask
    );

    // Scoreboard side.
    modport slave (
        input  id_valid,
        input  id_rs1,
        input  id_rs2,
        input  id_rs1_used,
        input  id_rs2_used,
        input  id_rd,
        input  id_regwrite,
        input  id_load,
        input  flush,
        input  mem_stall,
        output pc_hold,
        output ifid_hold,
        output ifid_flush,
        output idex_bubble,
        output pipe_freeze,
        output fwd_a_e,
        output fwd_b_e,
        output busy_mask
    );

endinterface

// File: rtl/xgriscv_src_match.sv
// xgriscv source operand matcher.
// Finds the youngest in-flight writer of one source register.
module xgriscv_src_match
    import xgriscv_pipe_pkg::sbEntry_t;
    import xgriscv_pipe_pkg::entryWrites;
#(
    parameter int RFIDX_WIDTH = 5,
    parameter int NSTAGES     = 3,
    parameter int FW          = 3
) (
    input  sbEntry_t [NSTAGES-1:0]   entries,
    input  logic [RFIDX_WIDTH-1:0]   rs,
    input  logic                     used,
    output logic                     hit,
    output logic [FW-1:0]            stage,
    output logic                     isLoad
);

    logic srcLive;

    // x0 is hardwired, so it never waits on or forwards from anyone.
    assign srcLive = used && (rs != '0);

    // Scan oldest to youngest; the last hit (youngest stage) wins.
    always_comb begin
        hit    = 1'b0;
        stage  = '0;
        isLoad = 1'b0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (srcLive && entryWrites(entries[k]) &&
                (entries[k].rd == rs)) begin
                hit    = 1'b1;
                stage  = FW'(k + 1);
                isLoad = entries[k].load;
            end
        end
    end

endmodule

// File: rtl/xgriscv_scoreboard.sv
// xgriscv hazard and forwarding scoreboard.
// Tracks post-decode writers; drives stalls, flushes and EX forward selects.
module xgriscv_scoreboard
    import xgriscv_pipe_pkg::sbEntry_t;
    import xgriscv_pipe_pkg::entryWrites;
    import xgriscv_pipe_pkg::FWD_RF;
#(
    parameter int RFIDX_WIDTH      = 5,
    parameter int NSTAGES          = 3,
    parameter int LOAD_READY       = 2,
    parameter int RF_WRITE_THROUGH = 1,
    parameter int FW               = 3
) (
    input  logic               clk,
    input  logic               reset,
    xgriscv_scoreboard_if.slave sb
);

    if (NSTAGES < 2 || NSTAGES > 6) begin : gBadStages
        $error("xgriscv_scoreboard: NSTAGES must be 2..6");
    end
    if (LOAD_READY < 2 || LOAD_READY > NSTAGES) begin : gBadLoadReady
        $error("xgriscv_scoreboard: LOAD_READY must be 2..NSTAGES");
    end
    if ((1 << FW) < NSTAGES + 1) begin : gBadFw
        $error("xgriscv_scoreboard: FW too narrow for NSTAGES");
    end

    sbEntry_t [NSTAGES-1:0] stageQ;
    sbEntry_t               idEntry;

    logic          hitA;
    logic          hitB;
    logic          loadA;
    logic          loadB;
    logic [FW-1:0] stageA;
    logic [FW-1:0] stageB;
    logic [FW-1:0] fwdSelA;
    logic [FW-1:0] fwdSelB;
    logic [FW-1:0] fwdAQ;
    logic [FW-1:0] fwdBQ;
    logic          hazA;
    logic          hazB;
    logic          stallId;

    logic               pcHold;
    logic               ifidHold;
    logic               ifidFlush;
    logic               idexBubble;
    logic               pipeFreeze;
    logic [NSTAGES-1:0] busyMask;

    // A load matched at stage k reaches stage k+1 when the consumer is in EX;
    // its data only exists at the output of LOAD_READY, so k < LOAD_READY waits.
    // Without write-through, a writer sitting in WB is not yet visible to ID.
    function automatic logic opHazard(
        input logic          hit,
        input logic          isLd,
        input logic [FW-1:0] stg
    );
        logic loadUse;
        logic wbWait;
        loadUse = isLd && (int'(stg) < LOAD_READY);
        wbWait  = (RF_WRITE_THROUGH == 0) && (int'(stg) == NSTAGES);
        return hit && (loadUse || wbWait);
    endfunction

    // Producer at stage k moves to k+1 by the time the consumer is in EX.
    // A WB-stage writer is served by the register file instead.
    function automatic logic [FW-1:0] fwdSel(
        input logic          hit,
        input logic [FW-1:0] stg
    );
        if (hit && (int'(stg) < NSTAGES)) begin
            return stg + FW'(1);
        end
        return FW'(FWD_RF);
    endfunction

    assign idEntry.valid    = sb.id_valid;
    assign idEntry.rd       = sb.id_rd;
    assign idEntry.regwrite = sb.id_regwrite;
    assign idEntry.load     = sb.id_load;

    xgriscv_src_match #(
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .NSTAGES     (NSTAGES),
        .FW          (FW)
    ) uMatchA (
        .entries (stageQ),
        .rs      (sb.id_rs1),
        .used    (sb.id_rs1_used),
        .hit     (hitA),
        .stage   (stageA),
        .isLoad  (loadA)
    );

    xgriscv_src_match #(
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .NSTAGES     (NSTAGES),
        .FW          (FW)
    ) uMatchB (
        .entries (stageQ),
        .rs      (sb.id_rs2),
        .used    (sb.id_rs2_used),
        .hit     (hitB),
        .stage   (stageB),
        .isLoad  (loadB)
    );

    assign hazA    = opHazard(hitA, loadA, stageA);
    assign hazB    = opHazard(hitB, loadB, stageB);
    assign stallId = sb.id_valid && (hazA || hazB);
    assign fwdSelA = fwdSel(hitA, stageA);
    assign fwdSelB = fwdSel(hitB, stageB);

    // Resolve freeze > flush > load-use/WB stall into pipeline controls.
    always_comb begin
        pcHold     = 1'b0;
        ifidHold   = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        pipeFreeze = 1'b0;
        priority case (1'b1)
            sb.mem_stall: begin
                pipeFreeze = 1'b1;
                pcHold     = 1'b1;
                ifidHold   = 1'b1;
            end
            sb.flush: begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
            end
            stallId: begin
                pcHold     = 1'b1;
                ifidHold   = 1'b1;
                idexBubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Report which stages hold a live register writer.
    always_comb begin
        busyMask = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            busyMask[k] = entryWrites(stageQ[k]);
        end
    end

    // Shift entries down the pipe and latch EX selects unless frozen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stageQ <= '0;
            fwdAQ  <= FW'(FWD_RF);
            fwdBQ  <= FW'(FWD_RF);
        end else if (!pipeFreeze) begin
            if (idexBubble) begin
                stageQ[0] <= '0;
                fwdAQ     <= FW'(FWD_RF);
                fwdBQ     <= FW'(FWD_RF);
            end else begin
                stageQ[0] <= idEntry;
                fwdAQ     <= fwdSelA;
                fwdBQ     <= fwdSelB;
            end
            for (int k = 1; k < NSTAGES; k++) begin
                stageQ[k] <= stageQ[k-1];
            end
        end
    end

    assign sb.pc_hold     = pcHold;
    assign sb.ifid_hold   = ifidHold;
    assign sb.ifid_flush  = ifidFlush;
    assign sb.idex_bubble = idexBubble;
    assign sb.pipe_freeze = pipeFreeze;
    assign sb.fwd_a_e     = fwdAQ;
    assign sb.fwd_b_e     = fwdBQ;
    assign sb.busy_mask   = busyMask;

endmodule

// File: tb/tb_xgriscv_scoreboard.sv
// xgriscv scoreboard testbench.
// Directed scenarios on a 3-stage and a 4-stage no-write-through instance.
module tb_xgriscv_scoreboard;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int nTests = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    xgriscv_scoreboard_if #(.RFIDX_WIDTH(5), .NSTAGES(3), .FW(3)) ifA ();
    xgriscv_scoreboard_if #(.RFIDX_WIDTH(5), .NSTAGES(4), .FW(3)) ifB ();

    xgriscv_scoreboard #(
        .RFIDX_WIDTH(5), .NSTAGES(3), .LOAD_READY(2),
        .RF_WRITE_THROUGH(1), .FW(3)
    ) dutA (.clk(clk), .reset(rstN), .sb(ifA));

    xgriscv_scoreboard #(
        .RFIDX_WIDTH(5), .NSTAGES(4), .LOAD_READY(3),
        .RF_WRITE_THROUGH(0), .FW(3)
    ) dutB (.clk(clk), .reset(rstN), .sb(ifB));

    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_FRZ   = 5'b11001;

    function automatic logic [4:0] ctlA();
        return {ifA.pc_hold, ifA.ifid_hold, ifA.ifid_flush,
                ifA.idex_bubble, ifA.pipe_freeze};
    endfunction

    function automatic logic [4:0] ctlB();
        return {ifB.pc_hold, ifB.ifid_hold, ifB.ifid_flush,
                ifB.idex_bubble, ifB.pipe_freeze};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drvA(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
        ifA.id_valid = v; ifA.id_rs1 = r1; ifA.id_rs1_used = u1;
        ifA.id_rs2 = r2; ifA.id_rs2_used = u2;
        ifA.id_rd = rd; ifA.id_regwrite = rw; ifA.id_load = ld;
    endtask

    task automatic drvB(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
        ifB.id_valid = v; ifB.id_rs1 = r1; ifB.id_rs1_used = u1;
        ifB.id_rs2 = r2; ifB.id_rs2_used = u2;
        ifB.id_rd = rd; ifB.id_regwrite = rw; ifB.id_load = ld;
    endtask

    task automatic drainA();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic drainB();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        ifA.flush = 0; ifA.mem_stall = 0;
        ifB.flush = 0; ifB.mem_stall = 0;
        tick(); tick();
        rstN = 1'b1;
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL rst_ctlA got %b want %b", ctlA(), C_NONE); end
        nTests++; if (ifA.busy_mask !== 3'b000) begin nFail++; $display("FAIL rst_busyA got %b want 000", ifA.busy_mask); end
        nTests++; if (ifA.fwd_a_e !== 3'd0) begin nFail++; $display("FAIL rst_fwdaA got %0d want 0", ifA.fwd_a_e); end
        nTests++; if (ifA.fwd_b_e !== 3'd0) begin nFail++; $display("FAIL rst_fwdbA got %0d want 0", ifA.fwd_b_e); end
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL rst_ctlB got %b want %b", ctlB(), C_NONE); end
        nTests++; if (ifB.busy_mask !== 4'b0000) begin nFail++; $display("FAIL rst_busyB got %b want 0000", ifB.busy_mask); end
    endtask

    task automatic test_forward();
        drvA(1, 1, 1, 2, 1, 5, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL fw_c0 got %b want %b", ctlA(), C_NONE); end
        tick();
        drvA(1, 5, 1, 0, 0, 8, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL fw_nostall got %b want %b", ctlA(), C_NONE); end
        nTests++; if (ifA.busy_mask !== 3'b001) begin nFail++; $display("FAIL fw_busy1 got %b want 001", ifA.busy_mask); end
        tick();
        drvA(1, 5, 1, 3, 1, 9, 1, 0);
        #1;
        nTests++; if (ifA.fwd_a_e !== 3'd2) begin nFail++; $display("FAIL fw_a2 got %0d want 2", ifA.fwd_a_e); end
        nTests++; if (ifA.fwd_b_e !== 3'd0) begin nFail++; $display("FAIL fw_b0 got %0d want 0", ifA.fwd_b_e); end
        nTests++; if (ifA.busy_mask !== 3'b011) begin nFail++; $display("FAIL fw_busy2 got %b want 011", ifA.busy_mask); end
        tick();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.fwd_a_e !== 3'd3) begin nFail++; $display("FAIL fw_a3 got %0d want 3", ifA.fwd_a_e); end
        drainA();
    endtask

    task automatic test_load_use();
        drvA(1, 1, 1, 0, 0, 6, 1, 1);
        tick();
        drvA(1, 3, 1, 6, 1, 10, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_STALL) begin nFail++; $display("FAIL lu_stall got %b want %b", ctlA(), C_STALL); end
        tick();
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL lu_release got %b want %b", ctlA(), C_NONE); end
        nTests++; if (ifA.busy_mask !== 3'b010) begin nFail++; $display("FAIL lu_busy got %b want 010", ifA.busy_mask); end
        nTests++; if (ifA.fwd_b_e !== 3'd0) begin nFail++; $display("FAIL lu_bubble_fwd got %0d want 0", ifA.fwd_b_e); end
        tick();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.fwd_b_e !== 3'd3) begin nFail++; $display("FAIL lu_fwd_b3 got %0d want 3", ifA.fwd_b_e); end
        drainA();
    endtask

    task automatic test_both_operands();
        drvA(1, 1, 1, 0, 0, 11, 1, 1);
        tick();
        drvA(1, 11, 1, 11, 1, 12, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_STALL) begin nFail++; $display("FAIL both_stall got %b want %b", ctlA(), C_STALL); end
        tick();
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL both_single got %b want %b", ctlA(), C_NONE); end
        tick();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.fwd_a_e !== 3'd3) begin nFail++; $display("FAIL both_fwd_a got %0d want 3", ifA.fwd_a_e); end
        nTests++; if (ifA.fwd_b_e !== 3'd3) begin nFail++; $display("FAIL both_fwd_b got %0d want 3", ifA.fwd_b_e); end
        drainA();
    endtask

    task automatic test_back_to_back();
        drvA(1, 1, 1, 0, 0, 6, 1, 1);
        tick();
        drvA(1, 2, 1, 0, 0, 6, 1, 1);
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL b2b_ld2 got %b want %b", ctlA(), C_NONE); end
        tick();
        drvA(1, 6, 1, 0, 0, 13, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_STALL) begin nFail++; $display("FAIL b2b_stall got %b want %b", ctlA(), C_STALL); end
        tick();
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL b2b_release got %b want %b", ctlA(), C_NONE); end
        tick();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.fwd_a_e !== 3'd3) begin nFail++; $display("FAIL b2b_fwd got %0d want 3", ifA.fwd_a_e); end
        drainA();
    endtask

    task automatic test_x0_and_invalid();
        drvA(1, 1, 1, 2, 1, 0, 1, 1);
        tick();
        drvA(1, 0, 1, 0, 1, 14, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL x0_nostall got %b want %b", ctlA(), C_NONE); end
        tick();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.fwd_a_e !== 3'd0) begin nFail++; $display("FAIL x0_fwd got %0d want 0", ifA.fwd_a_e); end
        drainA();
        drvA(1, 1, 1, 0, 0, 6, 1, 1);
        tick();
        drvA(0, 6, 1, 6, 1, 15, 1, 0);
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL inv_nostall got %b want %b", ctlA(), C_NONE); end
        tick();
        #1;
        nTests++; if (ifA.busy_mask !== 3'b010) begin nFail++; $display("FAIL inv_busy got %b want 010", ifA.busy_mask); end
        drainA();
    endtask

    task automatic test_flush();
        drvA(1, 1, 1, 0, 0, 12, 1, 1);
        tick();
        drvA(1, 12, 1, 0, 0, 16, 1, 0);
        ifA.flush = 1'b1;
        #1;
        nTests++; if (ctlA() !== C_FLUSH) begin nFail++; $display("FAIL fl_ctl got %b want %b", ctlA(), C_FLUSH); end
        tick();
        ifA.flush = 1'b0;
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.busy_mask !== 3'b010) begin nFail++; $display("FAIL fl_busy got %b want 010", ifA.busy_mask); end
        nTests++; if (ifA.fwd_a_e !== 3'd0) begin nFail++; $display("FAIL fl_fwd got %0d want 0", ifA.fwd_a_e); end
        drainA();
    endtask

    task automatic test_mem_stall();
        drvA(1, 1, 1, 2, 1, 14, 1, 0);
        tick();
        drvA(1, 14, 1, 0, 0, 13, 1, 1);
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL ms_pre got %b want %b", ctlA(), C_NONE); end
        tick();
        drvA(1, 0, 0, 13, 1, 16, 1, 0);
        ifA.mem_stall = 1'b1;
        #1;
        nTests++; if (ctlA() !== C_FRZ) begin nFail++; $display("FAIL ms_frz1 got %b want %b", ctlA(), C_FRZ); end
        nTests++; if (ifA.busy_mask !== 3'b011) begin nFail++; $display("FAIL ms_busy1 got %b want 011", ifA.busy_mask); end
        nTests++; if (ifA.fwd_a_e !== 3'd2) begin nFail++; $display("FAIL ms_fwd1 got %0d want 2", ifA.fwd_a_e); end
        tick();
        ifA.flush = 1'b1;
        #1;
        nTests++; if (ctlA() !== C_FRZ) begin nFail++; $display("FAIL ms_flush_ign got %b want %b", ctlA(), C_FRZ); end
        nTests++; if (ifA.busy_mask !== 3'b011) begin nFail++; $display("FAIL ms_busy2 got %b want 011", ifA.busy_mask); end
        nTests++; if (ifA.fwd_a_e !== 3'd2) begin nFail++; $display("FAIL ms_fwd2 got %0d want 2", ifA.fwd_a_e); end
        tick();
        ifA.flush = 1'b0;
        #1;
        nTests++; if (ifA.busy_mask !== 3'b011) begin nFail++; $display("FAIL ms_busy3 got %b want 011", ifA.busy_mask); end
        nTests++; if (ifA.fwd_a_e !== 3'd2) begin nFail++; $display("FAIL ms_fwd3 got %0d want 2", ifA.fwd_a_e); end
        tick();
        ifA.mem_stall = 1'b0;
        #1;
        nTests++; if (ctlA() !== C_STALL) begin nFail++; $display("FAIL ms_resume got %b want %b", ctlA(), C_STALL); end
        nTests++; if (ifA.fwd_a_e !== 3'd2) begin nFail++; $display("FAIL ms_fwd4 got %0d want 2", ifA.fwd_a_e); end
        tick();
        #1;
        nTests++; if (ctlA() !== C_NONE) begin nFail++; $display("FAIL ms_go got %b want %b", ctlA(), C_NONE); end
        nTests++; if (ifA.busy_mask !== 3'b110) begin nFail++; $display("FAIL ms_busy5 got %b want 110", ifA.busy_mask); end
        nTests++; if (ifA.fwd_a_e !== 3'd0) begin nFail++; $display("FAIL ms_fwd5 got %0d want 0", ifA.fwd_a_e); end
        tick();
        drvA(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifA.fwd_b_e !== 3'd3) begin nFail++; $display("FAIL ms_fwd_b got %0d want 3", ifA.fwd_b_e); end
        drainA();
    endtask

    task automatic test_load_latency();
        drvB(1, 1, 1, 0, 0, 7, 1, 1);
        tick();
        drvB(1, 7, 1, 0, 0, 17, 1, 0);
        #1;
        nTests++; if (ctlB() !== C_STALL) begin nFail++; $display("FAIL ll_s1 got %b want %b", ctlB(), C_STALL); end
        tick();
        #1;
        nTests++; if (ctlB() !== C_STALL) begin nFail++; $display("FAIL ll_s2 got %b want %b", ctlB(), C_STALL); end
        tick();
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL ll_s3 got %b want %b", ctlB(), C_NONE); end
        tick();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifB.fwd_a_e !== 3'd4) begin nFail++; $display("FAIL ll_fwd_a got %0d want 4", ifB.fwd_a_e); end
        drainB();
        drvB(1, 1, 1, 0, 0, 7, 1, 1);
        tick();
        drvB(1, 1, 1, 2, 1, 20, 1, 0);
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL ll2_mid got %b want %b", ctlB(), C_NONE); end
        tick();
        drvB(1, 0, 0, 7, 1, 18, 1, 0);
        #1;
        nTests++; if (ctlB() !== C_STALL) begin nFail++; $display("FAIL ll2_s1 got %b want %b", ctlB(), C_STALL); end
        tick();
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL ll2_s2 got %b want %b", ctlB(), C_NONE); end
        tick();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifB.fwd_b_e !== 3'd4) begin nFail++; $display("FAIL ll2_fwd_b got %0d want 4", ifB.fwd_b_e); end
        drainB();
    endtask

    task automatic test_wb_hazard();
        drvB(1, 1, 1, 2, 1, 15, 1, 0);
        tick();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        drvB(1, 15, 1, 0, 0, 19, 1, 0);
        #1;
        nTests++; if (ctlB() !== C_STALL) begin nFail++; $display("FAIL wb_stall got %b want %b", ctlB(), C_STALL); end
        nTests++; if (ifB.busy_mask !== 4'b1000) begin nFail++; $display("FAIL wb_busy got %b want 1000", ifB.busy_mask); end
        tick();
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL wb_release got %b want %b", ctlB(), C_NONE); end
        tick();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nTests++; if (ifB.fwd_a_e !== 3'd0) begin nFail++; $display("FAIL wb_fwd got %0d want 0", ifB.fwd_a_e); end
        drainB();
        drvB(1, 1, 1, 2, 1, 0, 1, 0);
        tick();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        drvB(1, 0, 1, 0, 1, 19, 1, 0);
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL wb_x0 got %b want %b", ctlB(), C_NONE); end
        drainB();
        drvB(1, 1, 1, 2, 1, 15, 1, 0);
        tick();
        drvB(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        drvB(1, 15, 1, 0, 0, 19, 1, 0);
        #1;
        nTests++; if (ctlB() !== C_STALL) begin nFail++; $display("FAIL rs_prestall got %b want %b", ctlB(), C_STALL); end
        rstN = 1'b0;
        tick();
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL rs_ctl got %b want %b", ctlB(), C_NONE); end
        nTests++; if (ifB.busy_mask !== 4'b0000) begin nFail++; $display("FAIL rs_busy got %b want 0000", ifB.busy_mask); end
        nTests++; if (ifB.fwd_a_e !== 3'd0) begin nFail++; $display("FAIL rs_fwd_a got %0d want 0", ifB.fwd_a_e); end
        nTests++; if (ifB.fwd_b_e !== 3'd0) begin nFail++; $display("FAIL rs_fwd_b got %0d want 0", ifB.fwd_b_e); end
        rstN = 1'b1;
        tick();
        #1;
        nTests++; if (ctlB() !== C_NONE) begin nFail++; $display("FAIL rs_post got %b want %b", ctlB(), C_NONE); end
        drainB();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_both_operands();
        test_back_to_back();
        test_x0_and_invalid();
        test_flush();
        test_mem_stall();
        test_load_latency();
        test_wb_hazard();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
